// File: rtl/base_mem_reader_pkg.sv
// Shared types and constants for the base_mem_reader block.
package base_mem_reader_pkg;

    localparam int DATA_W = 32;
    localparam logic [3:0] BYTE_ENABLE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/base_mem_reader_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; reset flushes it.
module base_mem_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    assign head   = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/base_mem_reader.sv
// Avalon-MM read master streaming a word block into a valid/ready stream.
// Optional running checksum enabled by defining BASE_MEM_READER_CHECKSUM_EN.
module base_mem_reader
    import base_mem_reader_pkg::*;
#(
    parameter int DEPTH        = 5000,
    parameter int ADDR_W       = 13,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [12:0]       length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]              state;
    logic [ADDR_W-1:0]       addr;
    logic [12:0]             issued;
    logic [12:0]             length_reg;
    logic [READ_LATENCY-1:0] inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    issue;
    logic                    pop;
    logic                    drain_ok;
    int                      inflight_cnt;

    assign mem_write      = 1'b0;
    assign mem_byteenable = BYTE_ENABLE_ALL;
    assign mem_writedata  = '0;
    assign mem_clken      = 1'b1;

    assign busy           = (state == S_RUN) || (state == S_DRAIN);
    assign done           = (state == S_DONE);
    assign mem_address    = addr;
    assign mem_chipselect = issue;
    assign out_valid      = !fifo_empty;
    assign pop            = out_valid && out_ready;

    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (inflight[i]) begin
                inflight_cnt = inflight_cnt + 1;
            end
        end
    end

    // Credit uses registered counts only, so a pop frees a slot one cycle later.
    assign issue = (state == S_RUN) && (issued < length_reg) &&
                   ((int'(fifo_count) + inflight_cnt) < FIFO_DEPTH);

    assign drain_ok = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            issued     <= '0;
            length_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= base_addr;
                        length_reg <= length;
                        issued     <= '0;
                        state      <= (length == 13'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        addr   <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
                        issued <= issued + 13'd1;
                    end
                    if (issued == length_reg) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_ok) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    inflight <= '0;
                end else begin
                    inflight <= issue;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clk) begin
                if (reset) begin
                    inflight <= '0;
                end else begin
                    inflight <= {inflight[READ_LATENCY-2:0], issue};
                end
            end
        end
    endgenerate

    base_mem_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight[READ_LATENCY-1]),
        .push_data (mem_readdata),
        .pop       (pop),
        .head      (out_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef BASE_MEM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_reg <= '0;
        end else if ((state == S_IDLE) && start) begin
            sum_reg <= '0;
        end else if (pop) begin
            sum_reg <= sum_reg + out_data;
        end
    end

    assign checksum = sum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_base_mem_reader.sv
// Directed, table-driven bench for base_mem_reader with a 1-cycle memory model.
module tb_base_mem_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [12:0] length;
    logic        busy;
    logic        done;
    logic [12:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] checksum;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

`ifdef BASE_MEM_READER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic [31:0] mem_model [5000];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_chipselect) begin
            mem_readdata <= mem_model[mem_address];
        end
    end

    base_mem_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .checksum       (checksum)
    );

    typedef struct {
        int          base;
        int          len;
        int          ready_mode;
        bit          poke_start;
        int          exp_first_valid;
        int          exp_done;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t vectors [5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int          k;
        int          done_cyc;
        int          first_valid;
        int          credit_viol;
        bit          busy_seen;
        bit          busy_at_done;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [31:0] sum_at_done;
        logic [31:0] words [$];
        int          addrs [$];

        @(negedge clk);
        base_addr   = 13'(v.base);
        length      = 13'(v.len);
        start       = 1'b1;
        out_ready   = 1'b1;
        k           = cyc;
        done_cyc    = -1;
        first_valid = -1;
        credit_viol = 0;
        busy_seen   = 1'b0;
        busy_at_done = 1'b0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        sum_at_done = '0;

        for (int step = 0; step < 400 && done_cyc < 0; step++) begin
            @(negedge clk);
            start     = 1'b0;
            base_addr = 13'(v.base);
            length    = 13'(v.len);
            if (v.poke_start && step == 3) begin
                start     = 1'b1;
                base_addr = 13'd50;
                length    = 13'd2;
            end
            out_ready = (v.ready_mode == 0) ? 1'b1 : ((step % 4) == 3);
            #1;
            if (prev_stall) begin
                checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
                checkOutput("hold_data", out_data, prev_data);
            end
            if (busy) busy_seen = 1'b1;
            if (mem_chipselect) begin
                if (addrs.size() - words.size() >= 4) credit_viol++;
                addrs.push_back(int'(mem_address));
            end
            if (out_valid && first_valid < 0) first_valid = cyc - k;
            if (out_valid && out_ready) words.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                done_cyc     = cyc - k;
                sum_at_done  = checksum;
                busy_at_done = busy;
            end
        end
        start = 1'b0;

        checkOutput("done_seen", {31'b0, done_cyc >= 0}, 32'd1);
        if (v.exp_done >= 0) checkOutput("done_latency", done_cyc, v.exp_done);
        checkOutput("first_valid_latency", first_valid, v.exp_first_valid);
        checkOutput("busy_at_done", {31'b0, busy_at_done}, 32'd0);
        checkOutput("word_count", words.size(), v.len);
        checkOutput("read_count", addrs.size(), v.len);
        checkOutput("credit_violations", credit_viol, 0);
        if (v.len == 0) checkOutput("busy_len0", {31'b0, busy_seen}, 32'd0);
        for (int i = 0; i < words.size() && i < v.len; i++) begin
            checkOutput($sformatf("word[%0d]", i), words[i], (v.base + i) % 5000);
        end
        for (int i = 0; i < addrs.size() && i < v.len; i++) begin
            checkOutput($sformatf("addr[%0d]", i), addrs[i], (v.base + i) % 5000);
        end
        checkOutput("checksum_at_done", sum_at_done, CK_EN ? v.exp_sum : 32'd0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("checksum_hold", checksum, CK_EN ? v.exp_sum : 32'd0);
    endtask

    initial begin
        int cs_seen;
        bit bad;

        for (int i = 0; i < 5000; i++) mem_model[i] = i;

        vectors[0] = '{base: 0,    len: 8,  ready_mode: 0, poke_start: 0, exp_first_valid: 3,  exp_done: 11, exp_sum: 32'd28};
        vectors[1] = '{base: 4996, len: 6,  ready_mode: 0, poke_start: 0, exp_first_valid: 3,  exp_done: 9,  exp_sum: 32'd19991};
        vectors[2] = '{base: 0,    len: 0,  ready_mode: 0, poke_start: 0, exp_first_valid: -1, exp_done: 1,  exp_sum: 32'd0};
        vectors[3] = '{base: 200,  len: 16, ready_mode: 1, poke_start: 0, exp_first_valid: 3,  exp_done: -1, exp_sum: 32'd3320};
        vectors[4] = '{base: 1,    len: 10, ready_mode: 0, poke_start: 1, exp_first_valid: 3,  exp_done: 13, exp_sum: 32'd55};

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_chipselect", {31'b0, mem_chipselect}, 32'd0);
        checkOutput("reset_address", {19'b0, mem_address}, 32'd0);
        checkOutput("reset_checksum", checksum, 32'd0);
        checkOutput("const_write", {31'b0, mem_write}, 32'd0);
        checkOutput("const_byteenable", {28'b0, mem_byteenable}, 32'hF);
        checkOutput("const_writedata", mem_writedata, 32'd0);
        checkOutput("const_clken", {31'b0, mem_clken}, 32'd1);

        for (int v = 0; v < 5; v++) begin
            $display("[TB] vector %0d: base=%0d len=%0d", v, vectors[v].base, vectors[v].len);
            applyStimulus(vectors[v]);
        end

        $display("[TB] reset during RUN");
        @(negedge clk);
        base_addr = 13'd300;
        length    = 13'd20;
        start     = 1'b1;
        out_ready = 1'b1;
        cs_seen   = 0;
        for (int step = 0; step < 50 && cs_seen < 5; step++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (mem_chipselect) cs_seen++;
        end
        checkOutput("reads_before_reset", cs_seen, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midreset_chipselect", {31'b0, mem_chipselect}, 32'd0);
        checkOutput("midreset_checksum", checksum, 32'd0);
        bad = 1'b0;
        for (int step = 0; step < 10; step++) begin
            @(negedge clk);
            #1;
            if (done || out_valid || busy || mem_chipselect) bad = 1'b1;
        end
        checkOutput("midreset_quiet", {31'b0, bad}, 32'd0);

        applyStimulus(vectors[0]);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
